rom_dl_ctrl: RTL and testbench
==============================

ROM_DL_CTRL -- requirements
Module: rom_dl_ctrl

Interface
REQ-001 SHALL have parameter ROM_INDEX, default 0, the ioctl_index value that selects a ROM download.
REQ-002 SHALL have parameter ROM_SIZE, default 'h58300, the expected total byte count of the ROM image.
REQ-003 SHALL have CLK  input  1  single clock; all logic is in this domain.
REQ-004 SHALL have RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have ioctl_download  input  1  high while the HPS streams a file.
REQ-006 SHALL have ioctl_index  input  8  file index of the current download.
REQ-007 SHALL have ioctl_wr  input  1  one-cycle byte strobe.
REQ-008 SHALL have ioctl_addr  input  25  byte address of ioctl_dout.
REQ-009 SHALL have ioctl_dout  input  8  download byte.
REQ-010 SHALL have ADDR_DL  output  25  registered write address to the ROM banks.
REQ-011 SHALL have DATA_DL  output  8  registered write data to the ROM banks.
REQ-012 SHALL have WR  output  1  registered one-cycle write strobe to the ROM banks.
REQ-013 SHALL have REGION  output  5  encoded target region of the current WR (0 = main CPU low ... 18 = colour PROM 3, 19 = beyond map).
REQ-014 SHALL have ROM_READY  output  1  high once a complete, valid image is loaded; holds the game in reset while low.
REQ-015 SHALL have DL_ERR  output  1  sticky error from the last download.
REQ-016 SHALL have CHECKSUM  output  8  modulo-256 sum of all accepted bytes.

Function
REQ-017 SHALL implement states IDLE, LOAD, DONE, ERROR.
REQ-018 SHALL move IDLE/DONE/ERROR -> LOAD on the rising edge of ioctl_download when ioctl_index == ROM_INDEX; downloads with other indices SHALL be ignored in every state.
REQ-019 SHALL, on entry to LOAD, clear the byte counter, CHECKSUM, DL_ERR and ROM_READY in the same cycle.
REQ-020 SHALL, in LOAD, accept an ioctl_wr whose ioctl_addr equals the byte counter and is < ROM_SIZE: WR, ADDR_DL, DATA_DL, REGION valid exactly one cycle later, counter +1, CHECKSUM += byte (wraps mod 256).
REQ-021 SHALL discard (no WR, no count, no sum) any ioctl_wr with ioctl_addr >= ROM_SIZE.
REQ-022 SHALL enter ERROR on any ioctl_wr with ioctl_addr < ROM_SIZE and != counter (gap or repeat); that write SHALL not be forwarded.
REQ-023 SHALL, on the falling edge of ioctl_download in LOAD, enter DONE if counter == ROM_SIZE, else ERROR.
REQ-024 SHALL, if ioctl_wr coincides with the falling edge, process the write first and include it in the REQ-023 count.
REQ-025 SHALL derive REGION from the address map: <'h4000:0, <'h8000:1, <'h10000:2, <'h12000:3, <'h14000:4, <'h16000:5, <'h18000:6, then 'h8000 steps to 'h58000:7..14, <'h58100:15, <'h58200:16, <'h58300:17, else 19 (18 reserved).
REQ-026 SHALL drive ROM_READY high only in DONE and DL_ERR high only in ERROR.
REQ-027 SHALL never assert WR outside LOAD, and WR SHALL never be high two consecutive cycles.

Reset
REQ-028 SHALL, on RESET, set state IDLE, counter 0, CHECKSUM 0, WR 0, ADDR_DL 0, DATA_DL 0, REGION 0, ROM_READY 0, DL_ERR 0; RESET mid-LOAD SHALL abandon the download and the remainder of that download SHALL be ignored until a new rising edge.

Structure
REQ-029 SHALL place the state enum, region enum and region boundary constants in shared package rom_pkg, reused by the bank selector.
REQ-030 SHALL contain one sub-module, rom_region_dec, the combinational address-to-REGION decoder.

Verification
REQ-031 SHALL test full sequential load of ROM_SIZE bytes, value = addr[7:0] -> ROM_READY=1, DL_ERR=0, CHECKSUM='h80 (sum over 'h58300 bytes, mod 256), WR count 'h58300.
REQ-032 SHALL test a short load ending at 'h1000 bytes -> ERROR, ROM_READY=0, DL_ERR=1.
REQ-033 SHALL test a skipped address (write 'h11 after 'h0F) -> ERROR immediately, address 'h11 not forwarded.
REQ-034 SHALL test writes at 'h58300..'h583FF appended to a full image -> no WR, DONE reached.
REQ-035 SHALL test a download with ioctl_index=1 during DONE -> no WR, ROM_READY stays 1.
REQ-036 SHALL test RESET asserted at byte 'h200 then a fresh full load -> IDLE, outputs zero, then DONE with correct CHECKSUM.

Source files
------------

// File: rtl/rom_pkg.sv
// rtl/rom_pkg.sv - shared download states, ROM region codes and region boundaries
package rom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE,
    ST_ERROR
  } dl_state_e;

  typedef enum logic [4:0] {
    RG_MAIN_LO = 5'd0,
    RG_MAIN_HI = 5'd1,
    RG_AREA_2  = 5'd2,
    RG_AREA_3  = 5'd3,
    RG_AREA_4  = 5'd4,
    RG_AREA_5  = 5'd5,
    RG_AREA_6  = 5'd6,
    RG_AREA_7  = 5'd7,
    RG_AREA_8  = 5'd8,
    RG_AREA_9  = 5'd9,
    RG_AREA_10 = 5'd10,
    RG_AREA_11 = 5'd11,
    RG_AREA_12 = 5'd12,
    RG_AREA_13 = 5'd13,
    RG_AREA_14 = 5'd14,
    RG_PROM_0  = 5'd15,
    RG_PROM_1  = 5'd16,
    RG_PROM_2  = 5'd17,
    RG_PROM_3  = 5'd18,
    RG_BEYOND  = 5'd19
  } region_e;

  localparam int REGION_COUNT = 18;

  // Exclusive upper byte address of each region, indexed by region code.
  localparam logic [24:0] REGION_LIMIT [REGION_COUNT] = '{
    25'h04000, 25'h08000, 25'h10000, 25'h12000, 25'h14000, 25'h16000,
    25'h18000, 25'h20000, 25'h28000, 25'h30000, 25'h38000, 25'h40000,
    25'h48000, 25'h50000, 25'h58000, 25'h58100, 25'h58200, 25'h58300
  };

endpackage

// File: rtl/rom_region_dec.sv
// rtl/rom_region_dec.sv - combinational byte address to ROM region decoder
module rom_region_dec
  import rom_pkg::*;
(
  input  logic [24:0] addr,
  output region_e     region
);

  // Scan from the top so the lowest matching limit wins.
  always_comb begin
    region = RG_BEYOND;
    for (int i = REGION_COUNT - 1; i >= 0; i--) begin
      if (addr < REGION_LIMIT[i]) region = region_e'(5'(i));
    end
  end

endmodule

// File: rtl/rom_dl_ctrl.sv
// rtl/rom_dl_ctrl.sv - ROM image download sequencer with gap check and checksum
module rom_dl_ctrl
  import rom_pkg::*;
#(
  parameter logic [7:0]  ROM_INDEX = 8'd0,
  parameter logic [24:0] ROM_SIZE  = 25'h58300
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [24:0] ADDR_DL,
  output logic [7:0]  DATA_DL,
  output logic        WR,
  output logic [4:0]  REGION,
  output logic        ROM_READY,
  output logic        DL_ERR,
  output logic [7:0]  CHECKSUM
);

  dl_state_e   state, state_nx;
  logic        dl_q;
  logic        idx_ok, dl_rise, dl_fall;
  logic        wr_hit, accept, bad_addr, enter_load;
  logic [24:0] cnt, cnt_after;
  region_e     dec_region;

  rom_region_dec u_region_dec (
    .addr   (ioctl_addr),
    .region (dec_region)
  );

  always_comb begin
    idx_ok     = (ioctl_index == ROM_INDEX);
    dl_rise    = ioctl_download && !dl_q && idx_ok;
    dl_fall    = !ioctl_download && dl_q;
    wr_hit     = (state == ST_LOAD) && ioctl_wr && idx_ok && (ioctl_addr < ROM_SIZE);
    accept     = wr_hit && (ioctl_addr == cnt);
    bad_addr   = wr_hit && (ioctl_addr != cnt);
    cnt_after  = accept ? cnt + 25'd1 : cnt;
    state_nx   = state;
    case (state)
      // A write landing on the falling edge is counted before the size check.
      ST_LOAD: begin
        if (bad_addr)     state_nx = ST_ERROR;
        else if (dl_fall) state_nx = (cnt_after == ROM_SIZE) ? ST_DONE : ST_ERROR;
      end
      default: begin
        if (dl_rise) state_nx = ST_LOAD;
      end
    endcase
    enter_load = (state != ST_LOAD) && (state_nx == ST_LOAD);
    ROM_READY  = (state == ST_DONE);
    DL_ERR     = (state == ST_ERROR);
  end

  // Sampled through reset so a download still running after reset shows no new rising edge.
  always_ff @(posedge CLK) begin
    dl_q <= ioctl_download;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      CHECKSUM <= '0;
      WR       <= 1'b0;
      ADDR_DL  <= '0;
      DATA_DL  <= '0;
      REGION   <= '0;
    end else begin
      state <= state_nx;
      WR    <= accept;
      if (enter_load) begin
        cnt      <= '0;
        CHECKSUM <= '0;
      end else if (accept) begin
        cnt      <= cnt_after;
        CHECKSUM <= CHECKSUM + ioctl_dout;
        ADDR_DL  <= ioctl_addr;
        DATA_DL  <= ioctl_dout;
        REGION   <= dec_region;
      end
    end
  end

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// tb/tb_rom_dl_ctrl.sv - randomized model-checked bench for rom_dl_ctrl
module tb_rom_dl_ctrl;
  import rom_pkg::*;

  localparam logic [24:0] RS = 25'h1100;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [24:0] ADDR_DL;
  logic [7:0]  DATA_DL;
  logic        WR;
  logic [4:0]  REGION;
  logic        ROM_READY;
  logic        DL_ERR;
  logic [7:0]  CHECKSUM;

  logic [24:0] rd_addr = '0;
  region_e     rd_region;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;
  logic [24:0] last_wr_addr = '0;
  bit chk_en = 0;
  bit wr_prev = 0;

  bit          m_load = 0, m_ready = 0, m_err = 0, m_prev_dl = 0;
  int          m_cnt = 0;
  logic [7:0]  m_sum = '0;
  bit          e_wr = 0;
  logic [24:0] e_addr = '0;
  logic [7:0]  e_data = '0;
  logic [4:0]  e_reg = '0;

  rom_dl_ctrl #(.ROM_INDEX(8'd0), .ROM_SIZE(RS)) dut (
    .CLK(CLK), .RESET(RESET), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ADDR_DL(ADDR_DL), .DATA_DL(DATA_DL), .WR(WR), .REGION(REGION),
    .ROM_READY(ROM_READY), .DL_ERR(DL_ERR), .CHECKSUM(CHECKSUM)
  );

  rom_region_dec u_dec_chk (.addr(rd_addr), .region(rd_region));

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] m_region(input logic [24:0] a);
    if (a < 25'h08000)      return 5'(a / 25'h4000);
    else if (a < 25'h10000) return 5'd2;
    else if (a < 25'h18000) return 5'(3 + (a - 25'h10000) / 25'h2000);
    else if (a < 25'h58000) return 5'(7 + (a - 25'h18000) / 25'h8000);
    else if (a < 25'h58300) return 5'(15 + (a - 25'h58000) / 25'h100);
    else                    return 5'd19;
  endfunction

  function automatic logic [7:0] ramp_sum(input int n);
    logic [7:0] s = '0;
    for (int i = 0; i < n; i++) s = s + 8'(i);
    return s;
  endfunction

  // Reference model: what the controller must do after each clock edge.
  always @(posedge CLK) begin
    e_wr = 0;
    if (RESET) begin
      m_load = 0; m_ready = 0; m_err = 0; m_cnt = 0; m_sum = '0;
      e_addr = '0; e_data = '0; e_reg = '0;
    end else if (!m_load) begin
      if (ioctl_download && !m_prev_dl && ioctl_index == 8'd0) begin
        m_load = 1; m_ready = 0; m_err = 0; m_cnt = 0; m_sum = '0;
      end
    end else begin
      if (ioctl_wr && ioctl_index == 8'd0 && ioctl_addr < RS) begin
        if (int'(ioctl_addr) == m_cnt) begin
          e_wr = 1; e_addr = ioctl_addr; e_data = ioctl_dout; e_reg = m_region(ioctl_addr);
          m_cnt++; m_sum = m_sum + ioctl_dout;
        end else begin
          m_load = 0; m_err = 1;
        end
      end
      if (m_load && !ioctl_download && m_prev_dl) begin
        m_load = 0;
        if (m_cnt == int'(RS)) m_ready = 1;
        else m_err = 1;
      end
    end
    m_prev_dl = ioctl_download;
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("wr", 32'(WR), 32'(e_wr));
      check("rom_ready", 32'(ROM_READY), 32'(m_ready));
      check("dl_err", 32'(DL_ERR), 32'(m_err));
      check("checksum", 32'(CHECKSUM), 32'(m_sum));
      check("wr_back_to_back", 32'(WR & wr_prev), 32'd0);
      if (e_wr) begin
        check("addr_dl", 32'(ADDR_DL), 32'(e_addr));
        check("data_dl", 32'(DATA_DL), 32'(e_data));
        check("region", 32'(REGION), 32'(e_reg));
      end
      if (WR) begin
        wr_count++;
        last_wr_addr = ADDR_DL;
      end
      wr_prev = WR;
    end
  end

  task automatic put(input logic [24:0] a, input logic [7:0] d, input bit drop);
    @(negedge CLK);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    if (drop) ioctl_download = 1'b0;
    @(negedge CLK);
    ioctl_wr = 1'b0;
    if ($urandom_range(3) == 0) @(negedge CLK);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(negedge CLK);
    ioctl_index = idx; ioctl_download = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic end_dl();
    @(negedge CLK);
    ioctl_download = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic load(input int n, input bit ramp, input bit drop_on_last);
    for (int i = 0; i < n; i++)
      put(25'(i), ramp ? 8'(i) : 8'($urandom), drop_on_last && (i == n - 1));
  endtask

  int base;

  initial begin
    check("model_ramp_sum_full_map", 32'(ramp_sum(32'h58300)), 32'h80);
    check("model_region_57fff", 32'(m_region(25'h57FFF)), 32'd14);
    check("model_region_58250", 32'(m_region(25'h58250)), 32'd17);
    check("model_region_58300", 32'(m_region(25'h58300)), 32'd19);

    for (int i = 0; i < REGION_COUNT; i++) begin
      rd_addr = REGION_LIMIT[i] - 25'd1; #1;
      check("dec_below_limit", 32'(rd_region), 32'(m_region(rd_addr)));
      rd_addr = REGION_LIMIT[i]; #1;
      check("dec_at_limit", 32'(rd_region), 32'(m_region(rd_addr)));
    end
    for (int i = 0; i < 40; i++) begin
      rd_addr = 25'($urandom_range(32'h5FFFF)); #1;
      check("dec_random", 32'(rd_region), 32'(m_region(rd_addr)));
    end

    repeat (3) @(posedge CLK);
    chk_en = 1;
    @(negedge CLK);
    check("rst_ready", 32'(ROM_READY), 32'd0);
    check("rst_err", 32'(DL_ERR), 32'd0);
    check("rst_addr", 32'(ADDR_DL), 32'd0);
    check("rst_region", 32'(REGION), 32'd0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    base = wr_count;
    start_dl(8'd0);
    load(int'(RS), 1, 1);
    repeat (3) @(negedge CLK);
    check("full_ready", 32'(ROM_READY), 32'd1);
    check("full_err", 32'(DL_ERR), 32'd0);
    check("full_checksum", 32'(CHECKSUM), 32'h80);
    check("full_wr_count", 32'(wr_count - base), 32'(RS));

    base = wr_count;
    start_dl(8'd1);
    for (int i = 0; i < 8; i++) put(25'(i), 8'($urandom), 0);
    end_dl();
    check("idx1_ready", 32'(ROM_READY), 32'd1);
    check("idx1_wr_count", 32'(wr_count - base), 32'd0);

    base = wr_count;
    start_dl(8'd0);
    load(32'h1000, 0, 0);
    end_dl();
    check("short_ready", 32'(ROM_READY), 32'd0);
    check("short_err", 32'(DL_ERR), 32'd1);
    check("short_wr_count", 32'(wr_count - base), 32'h1000);

    base = wr_count;
    start_dl(8'd0);
    load(16, 0, 0);
    put(25'h11, 8'h5A, 0);
    check("skip_err_now", 32'(DL_ERR), 32'd1);
    check("skip_last_addr", 32'(last_wr_addr), 32'h0F);
    check("skip_wr_count", 32'(wr_count - base), 32'd16);
    put(25'h10, 8'h01, 0);
    end_dl();
    check("skip_err_after", 32'(DL_ERR), 32'd1);

    base = wr_count;
    start_dl(8'd0);
    load(int'(RS), 0, 0);
    for (int i = 0; i < 256; i++) put(RS + 25'(i), 8'($urandom), 0);
    for (int i = 0; i < 16; i++) put(25'h58300 + 25'(i), 8'($urandom), 0);
    end_dl();
    check("append_ready", 32'(ROM_READY), 32'd1);
    check("append_err", 32'(DL_ERR), 32'd0);
    check("append_wr_count", 32'(wr_count - base), 32'(RS));

    start_dl(8'd0);
    load(32'h200, 0, 0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("mid_rst_ready", 32'(ROM_READY), 32'd0);
    check("mid_rst_err", 32'(DL_ERR), 32'd0);
    check("mid_rst_checksum", 32'(CHECKSUM), 32'd0);
    check("mid_rst_wr", 32'(WR), 32'd0);
    check("mid_rst_addr", 32'(ADDR_DL), 32'd0);
    check("mid_rst_data", 32'(DATA_DL), 32'd0);
    check("mid_rst_region", 32'(REGION), 32'd0);
    RESET = 1'b0;
    base = wr_count;
    for (int i = 0; i < 16; i++) put(25'h200 + 25'(i), 8'($urandom), 0);
    end_dl();
    check("post_rst_ignored", 32'(wr_count - base), 32'd0);
    check("post_rst_ready", 32'(ROM_READY), 32'd0);
    start_dl(8'd0);
    load(int'(RS), 1, 0);
    end_dl();
    check("fresh_ready", 32'(ROM_READY), 32'd1);
    check("fresh_checksum", 32'(CHECKSUM), 32'h80);
    check("fresh_wr_count", 32'(wr_count - base), 32'(RS));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
